gated_valid_pipe: RTL and testbench
===================================

Name: gated_valid_pipe

Overview:
Parametrised multi-lane, multi-stage datapath pipeline with per-lane predicate gating and valid/ready flow control. It generalises the fixed two-stage, single-bit, predicate-gated register chain into a LANES x WIDTH datapath with DEPTH stages, backpressure, flush, occupancy reporting and a sticky predicate-check error flag. It sits between codegen-emitted stages and downstream consumers that may stall.

Parameters:
WIDTH, 32, bits per lane (>=1)
LANES, 4, number of independent data lanes (>=1)
DEPTH, 2, number of register stages (>=1)
REQUIRE_ANY_PRED, 1, if 1, an accepted beat with all predicates 0 sets err_no_pred

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous pipeline clear
in_valid  input  1  upstream beat valid
in_ready  output  1  pipe accepts beat this cycle
in_pred  input  LANES  per-lane predicate; lane i is live when in_pred[i]=1
in_data  input  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
out_valid  output  1  beat available at last stage
out_ready  input  1  downstream accepts beat
out_pred  output  LANES  predicates carried with beat
out_data  output  LANES*WIDTH  gated lane data
occupancy  output  $clog2(DEPTH+1)  count of valid stages
err_no_pred  output  1  sticky predicate-check error

Behaviour:
- Reset (async, rst=1): all stage valid bits, predicate registers, data registers, occupancy and err_no_pred cleared to 0; out_valid=0, out_data=0, out_pred=0.
- Stage k (0..DEPTH-1) holds valid_k, pred_k[LANES], data_k. Stage 0 is fed from inputs; stage DEPTH-1 drives outputs.
- Ready chain (combinational): ready_DEPTH = out_ready; ready_k = !valid_k | ready_{k+1}; in_ready = ready_0 & !flush.
- Advance: stage k loads from stage k-1 (or inputs) when ready_k; valid_k <= incoming valid. Bubbles collapse; throughput 1 beat/cycle; latency DEPTH cycles from in transfer to out_valid with out_ready held 1.
- Gating: on load, data lane i is written only if incoming pred bit i=1; otherwise lane register holds its old value (no toggle). pred bits always load. Output lane i = out_pred[i] ? data_{DEPTH-1} lane i : 0.
- out_valid = valid_{DEPTH-1} & !flush. Transfer = out_valid & out_ready.
- Flush: when flush=1, no input or output transfer occurs; at next edge all valid_k <= 0 and pred_k <= 0; data registers untouched. Flush overrides simultaneous in_valid/out_ready.
- occupancy = popcount(valid_0..valid_{DEPTH-1}), registered view of current valid bits.
- err_no_pred: if REQUIRE_ANY_PRED=1 and in_valid & in_ready & (in_pred==0), set to 1 at next edge; cleared only by rst (not by flush). With REQUIRE_ANY_PRED=0 it is constant 0.
- Under `ASSERT_ON: out_valid must remain asserted and out_data/out_pred stable while out_valid & !out_ready & !flush.
- Reset mid-operation discards all in-flight beats immediately; no output transfer at/after reset assertion.

Test Plan:
- Streaming: DEPTH=2, out_ready=1, drive beats 1..8 with in_pred=4'hF -> out_valid rises 2 cycles after first accept, outputs 1..8 back-to-back in order, occupancy=2 steady.
- Gating: lane1 data 0xAAAA_AAAA pred=1, then 0x5555_5555 pred=0 -> second beat out lane1=0, internal lane1 register still 0xAAAA_AAAA; other lanes unaffected.
- Backpressure: fill with 3 beats, out_ready=0 for 5 cycles -> in_ready=0 once occupancy=2, out_data stable, no beat lost or duplicated on release.
- Flush: 2 beats in flight, flush=1 with in_valid=1, out_ready=1 -> no transfer that cycle, next cycle occupancy=0, out_valid=0, in_ready=1.
- Pred error: accept beat with in_pred=0 -> err_no_pred=1 next cycle, stays 1 through flush, clears only on rst; with REQUIRE_ANY_PRED=0 stays 0.
- Async reset: assert rst mid-stream between clock edges -> out_valid, out_data, occupancy go 0 immediately; after release pipe accepts new beats with DEPTH latency.

Source files
------------

// File: rtl/gated_valid_pipe.sv
// Multi-lane, multi-stage valid/ready pipeline with per-lane predicate gating.
// Lane data registers only toggle for live lanes; flush clears valid/pred but leaves data untouched.
module gated_valid_pipe #(
    parameter int WIDTH            = 32,
    parameter int LANES            = 4,
    parameter int DEPTH            = 2,
    parameter int REQUIRE_ANY_PRED = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0]             in_pred,
    input  logic [LANES*WIDTH-1:0]       in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES-1:0]             out_pred,
    output logic [LANES*WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         err_no_pred
);

    localparam int OCC_W = $clog2(DEPTH+1);

    typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;

    logic [DEPTH-1:0] valid_q;
    logic [LANES-1:0] pred_q [DEPTH];
    lanes_t           data_q [DEPTH];

    logic [DEPTH-1:0] ready;
    logic             all_full;
    logic [DEPTH-1:0] inc_valid;
    logic [LANES-1:0] inc_pred [DEPTH];
    lanes_t           inc_data [DEPTH];
    lanes_t           out_lanes;

    // A stage is ready unless it and every stage downstream of it are full and the sink stalls.
    always_comb begin
        all_full = 1'b1;
        ready    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            all_full = all_full & valid_q[k];
            ready[k] = !all_full | out_ready;
        end
    end

    always_comb begin
        inc_valid[0] = in_valid;
        inc_pred[0]  = in_pred;
        inc_data[0]  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            inc_valid[k] = valid_q[k-1];
            inc_pred[k]  = pred_q[k-1];
            inc_data[k]  = data_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                pred_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                pred_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= inc_valid[k];
                    pred_q[k]  <= inc_pred[k];
                    // Dead lanes keep their previous value to avoid needless toggling.
                    for (int i = 0; i < LANES; i++) begin
                        if (inc_pred[k][i]) begin
                            data_q[k][i] <= inc_data[k][i];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        out_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            if (pred_q[DEPTH-1][i]) begin
                out_lanes[i] = data_q[DEPTH-1][i];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(valid_q[k]);
        end
    end

    assign in_ready  = ready[0] & !flush;
    assign out_valid = valid_q[DEPTH-1] & !flush;
    assign out_pred  = pred_q[DEPTH-1];
    assign out_data  = out_lanes;

    // Sticky until reset; flush deliberately leaves it set.
    generate
        if (REQUIRE_ANY_PRED != 0) begin : g_err
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    err_no_pred <= 1'b0;
                end else if (in_valid && in_ready && (in_pred == '0)) begin
                    err_no_pred <= 1'b1;
                end
            end
        end else begin : g_no_err
            assign err_no_pred = 1'b0;
        end
    endgenerate

`ifdef ASSERT_ON
    property p_out_hold;
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=>
            (flush || (out_valid && $stable(out_data) && $stable(out_pred)));
    endproperty
    a_out_hold: assert property (p_out_hold);
`endif

endmodule

// File: tb/tb_gated_valid_pipe.sv
// Directed bench for gated_valid_pipe: queue-based reference model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_gated_valid_pipe;

    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int DEPTH = 2;
    localparam int DW    = LANES * WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [LANES-1:0] in_pred = '0;
    logic [DW-1:0]    in_data = '0;

    logic             in_ready, out_valid, err_no_pred;
    logic [LANES-1:0] out_pred;
    logic [DW-1:0]    out_data;
    logic [1:0]       occupancy;

    logic             in_ready_n, out_valid_n, err_no_pred_n;
    logic [LANES-1:0] out_pred_n;
    logic [DW-1:0]    out_data_n;
    logic [1:0]       occupancy_n;

    int checks = 0;
    int failures = 0;

    gated_valid_pipe #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH), .REQUIRE_ANY_PRED(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pred(in_pred), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pred(out_pred), .out_data(out_data), .occupancy(occupancy), .err_no_pred(err_no_pred)
    );

    gated_valid_pipe #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH), .REQUIRE_ANY_PRED(0)) dut_np (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_pred(in_pred), .in_data(in_data), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_pred(out_pred_n), .out_data(out_data_n), .occupancy(occupancy_n), .err_no_pred(err_no_pred_n)
    );

    always #5 clk = ~clk;

    // Reference model: beats in order (oldest first) with their stage position.
    logic [LANES-1:0] m_pred [$];
    logic [DW-1:0]    m_data [$];
    int               m_pos  [$];
    logic             m_err;
    logic             exp_ready, exp_valid, accept;
    int               lim;

    function automatic logic [DW-1:0] mask_lanes(input logic [LANES-1:0] p, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        for (int i = 0; i < LANES; i++) begin
            if (!p[i]) r[i*WIDTH +: WIDTH] = '0;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] beat(input int n);
        logic [WIDTH-1:0] w;
        w = WIDTH'(n);
        return {LANES{w}};
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [LANES-1:0] p, input logic [DW-1:0] d,
                                 input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_pred   = p;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic sampleNow;
        @(negedge clk);
        #1;
    endtask

    // Every cycle: compare both DUTs against the model, then advance the model by one edge.
    always @(negedge clk) begin
        if (rst) begin
            m_pred.delete();
            m_data.delete();
            m_pos.delete();
            m_err = 1'b0;
        end else begin
            exp_ready = !flush && ((m_pos.size() < DEPTH) || out_ready);
            exp_valid = !flush && (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
            checkOutput("m_in_ready", DW'(in_ready), DW'(exp_ready));
            checkOutput("m_out_valid", DW'(out_valid), DW'(exp_valid));
            checkOutput("m_occupancy", DW'(occupancy), DW'(m_pos.size()));
            checkOutput("m_err", DW'(err_no_pred), DW'(m_err));
            checkOutput("m_np_in_ready", DW'(in_ready_n), DW'(exp_ready));
            checkOutput("m_np_out_valid", DW'(out_valid_n), DW'(exp_valid));
            checkOutput("m_np_occupancy", DW'(occupancy_n), DW'(m_pos.size()));
            checkOutput("m_np_err", DW'(err_no_pred_n), DW'(0));
            if (exp_valid) begin
                checkOutput("m_out_pred", DW'(out_pred), DW'(m_pred[0]));
                checkOutput("m_out_data", out_data, mask_lanes(m_pred[0], m_data[0]));
                checkOutput("m_np_out_pred", DW'(out_pred_n), DW'(m_pred[0]));
                checkOutput("m_np_out_data", out_data_n, mask_lanes(m_pred[0], m_data[0]));
            end
            if (flush) begin
                m_pred.delete();
                m_data.delete();
                m_pos.delete();
            end else begin
                if (exp_valid && out_ready) begin
                    m_pred.delete(0);
                    m_data.delete(0);
                    m_pos.delete(0);
                end
                for (int i = 0; i < m_pos.size(); i++) begin
                    if (i == 0) lim = DEPTH;
                    else        lim = m_pos[i-1];
                    if (m_pos[i] + 1 < lim) m_pos[i] = m_pos[i] + 1;
                end
                accept = in_valid && exp_ready;
                if (accept) begin
                    m_pred.push_back(in_pred);
                    m_data.push_back(in_data);
                    m_pos.push_back(0);
                    if (in_pred == '0) m_err = 1'b1;
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sampleNow();
        checkOutput("rst_out_valid", DW'(out_valid), DW'(0));
        checkOutput("rst_out_data", out_data, DW'(0));
        checkOutput("rst_occupancy", DW'(occupancy), DW'(0));
        checkOutput("rst_err", DW'(err_no_pred), DW'(0));
        checkOutput("rst_in_ready", DW'(in_ready), DW'(1));

        // Streaming: beats 1..8, two-cycle latency, steady full occupancy
        for (int n = 1; n <= 8; n++) begin
            applyStimulus(1'b1, 4'hF, beat(n), 1'b1, 1'b0);
            if (n == 2) begin
                sampleNow();
                checkOutput("stream_first_latency", DW'(out_valid), DW'(0));
            end
            if (n >= 3) begin
                sampleNow();
                checkOutput("stream_data", out_data, beat(n - 2));
                checkOutput("stream_occ", DW'(occupancy), DW'(2));
            end
        end
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("stream_tail7", out_data, beat(7));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("stream_tail8", out_data, beat(8));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("stream_empty", DW'(occupancy), DW'(0));

        // Gating: lane1 live then dead
        applyStimulus(1'b1, 4'b0010, 128'h11111111_11111111_AAAAAAAA_11111111, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'b1101, 128'h55555555_55555555_55555555_55555555, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("gate_beat1", out_data, 128'h00000000_00000000_AAAAAAAA_00000000);
        checkOutput("gate_pred1", DW'(out_pred), DW'(4'b0010));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("gate_beat2", out_data, 128'h55555555_55555555_00000000_55555555);
        checkOutput("gate_lane_hold", DW'(dut.data_q[DEPTH-1][1]), DW'(32'hAAAAAAAA));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);

        // Backpressure: three beats, sink stalled five cycles
        applyStimulus(1'b1, 4'hF, beat(33), 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hF, beat(34), 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 4'hF, beat(35), 1'b0, 1'b0);
            sampleNow();
            checkOutput("bp_in_ready", DW'(in_ready), DW'(0));
            checkOutput("bp_hold_data", out_data, beat(33));
            checkOutput("bp_occ", DW'(occupancy), DW'(2));
        end
        applyStimulus(1'b1, 4'hF, beat(35), 1'b1, 1'b0);
        sampleNow();
        checkOutput("bp_release_data", out_data, beat(33));
        checkOutput("bp_release_ready", DW'(in_ready), DW'(1));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("bp_out2", out_data, beat(34));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("bp_out3", out_data, beat(35));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("bp_drained", DW'(occupancy), DW'(0));

        // Flush with two beats in flight and a competing input
        applyStimulus(1'b1, 4'hF, beat(65), 1'b1, 1'b0);
        applyStimulus(1'b1, 4'hF, beat(66), 1'b1, 1'b0);
        applyStimulus(1'b1, 4'hF, beat(67), 1'b1, 1'b1);
        sampleNow();
        checkOutput("flush_in_ready", DW'(in_ready), DW'(0));
        checkOutput("flush_out_valid", DW'(out_valid), DW'(0));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("flush_occ", DW'(occupancy), DW'(0));
        checkOutput("flush_after_valid", DW'(out_valid), DW'(0));
        checkOutput("flush_after_ready", DW'(in_ready), DW'(1));

        // Predicate error: sticky through flush, cleared by reset only
        applyStimulus(1'b1, 4'h0, beat(77), 1'b1, 1'b0);
        sampleNow();
        checkOutput("perr_before", DW'(err_no_pred), DW'(0));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("perr_set", DW'(err_no_pred), DW'(1));
        checkOutput("perr_np", DW'(err_no_pred_n), DW'(0));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b1);
        sampleNow();
        checkOutput("perr_flush", DW'(err_no_pred), DW'(1));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("perr_sticky", DW'(err_no_pred), DW'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        sampleNow();
        checkOutput("perr_reset", DW'(err_no_pred), DW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset between edges mid-stream
        applyStimulus(1'b1, 4'hF, beat(90), 1'b1, 1'b0);
        applyStimulus(1'b1, 4'hF, beat(91), 1'b1, 1'b0);
        applyStimulus(1'b1, 4'hF, beat(92), 1'b1, 1'b0);
        sampleNow();
        checkOutput("arst_pre_valid", DW'(out_valid), DW'(1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", DW'(out_valid), DW'(0));
        checkOutput("arst_out_data", out_data, DW'(0));
        checkOutput("arst_occ", DW'(occupancy), DW'(0));
        in_valid = 1'b0;
        in_pred  = '0;
        in_data  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 4'hF, beat(100), 1'b1, 1'b0);
        sampleNow();
        checkOutput("arst_new_occ0", DW'(occupancy), DW'(0));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("arst_new_occ1", DW'(occupancy), DW'(1));
        checkOutput("arst_new_notyet", DW'(out_valid), DW'(0));
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        checkOutput("arst_new_valid", DW'(out_valid), DW'(1));
        checkOutput("arst_new_data", out_data, beat(100));

        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'h0, '0, 1'b1, 1'b0);
        sampleNow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
